// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: opcodes, flag positions, FSM states.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 4;
  localparam int FLG_W  = 6;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_NEGB = 4'b0011;
  localparam logic [OP_W-1:0] OP_AND  = 4'b1000;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_OR   = 4'b1010;
  localparam logic [OP_W-1:0] OP_NOTB = 4'b1011;
  localparam logic [OP_W-1:0] OP_ROL  = 4'b1100;
  localparam logic [OP_W-1:0] OP_ROR  = 4'b1101;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b1110;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1111;

  // Flag vector layout on the response channel: {lt,gt,eq,ovf,carry,zero}
  localparam int FLG_ZERO  = 0;
  localparam int FLG_CARRY = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_EQ    = 3;
  localparam int FLG_GT    = 4;
  localparam int FLG_LT    = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal;
    case (op)
      OP_ADD, OP_SUB, OP_NEGB,
      OP_AND, OP_XOR, OP_OR, OP_NOTB,
      OP_ROL, OP_ROR, OP_SHL, OP_SHR: legal = 1'b1;
      default:                        legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Only add and subtract produce meaningful carry/overflow from the ALU.
  function automatic logic is_arith_op(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; pointer starts at port 0 and flips to the loser after each accepted grant.
// Latency: grant is combinational on req/en; pointer updates on the clock after the accept strobe.
// Backpressure: grants only while en is high; a lone requester wins regardless of the pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  input  logic       accept,
  input  logic       lock,
  output logic [1:0] gnt,
  output logic       win
);

  logic ptr_q;
  logic ptr_d;

  // Pick the winner and compute the pointer for the next arbitration round.
  always_comb begin
    win   = (req == 2'b11) ? ptr_q : req[1];
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en && (req != 2'b00)) begin
      gnt = win ? 2'b10 : 2'b01;
    end
    if (accept) begin
      // A locked grant keeps priority on the winning port.
      ptr_d = lock ? win : ~win;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto one registered ALU and returns result/flags per port; ALU_SHARE_LOCK_EN enables priority lock.
// Latency: legal op accepted in n -> alu_rw in n+1, response from n+3; illegal op response from n+1.
// Backpressure: one op in flight; request ready only in IDLE; response held until the owning port's ready.
module alu_share_ctrl
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req0_lock,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  input  logic              req1_lock,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_f,
  output logic [FLG_W-1:0]  rsp0_flags,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_f,
  output logic [FLG_W-1:0]  rsp1_flags,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_s,
  output logic              alu_rw,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zero,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  input  logic              alu_eq,
  input  logic              alu_gt,
  input  logic              alu_lt,
  output logic              busy,
  output logic              grant_id
);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   s_q, s_d;
  logic              grant_q, grant_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] f_q, f_d;
  logic [FLG_W-1:0]  flags_q, flags_d;

  logic [1:0]        gnt;
  logic              win;
  logic              accept;
  logic              lock_sel;
  logic [DATA_W-1:0] a_sel;
  logic [DATA_W-1:0] b_sel;
  logic [OP_W-1:0]   op_sel;
  logic              rsp_rdy_sel;

  assign accept = |(gnt & {req1_valid, req0_valid});

`ifdef ALU_SHARE_LOCK_EN
  assign lock_sel = win ? req1_lock : req0_lock;
`else
  logic lock_unused;
  assign lock_unused = req0_lock ^ req1_lock;
  assign lock_sel    = 1'b0;
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    ({req1_valid, req0_valid}),
    .en     (state_q == ST_IDLE),
    .accept (accept),
    .lock   (lock_sel),
    .gnt    (gnt),
    .win    (win)
  );

  // Steer the winning port's request fields and the owner's response ready.
  always_comb begin
    a_sel       = win ? req1_a  : req0_a;
    b_sel       = win ? req1_b  : req0_b;
    op_sel      = win ? req1_op : req0_op;
    rsp_rdy_sel = grant_q ? rsp1_ready : rsp0_ready;
  end

  // Sequencer: accept, issue to ALU, capture result, hold response.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    grant_d = grant_q;
    err_d   = err_q;
    f_d     = f_q;
    flags_d = flags_q;
    alu_rw  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          grant_d = win;
          if (is_legal_op(op_sel)) begin
            // ALU inputs only move on a legal accept so they hold otherwise.
            a_d     = a_sel;
            b_d     = b_sel;
            s_d     = op_sel;
            err_d   = 1'b0;
            state_d = ST_ISSUE;
          end else begin
            err_d   = 1'b1;
            f_d     = '0;
            flags_d = '0;
            state_d = ST_RESP;
          end
        end
      end
      ST_ISSUE: begin
        alu_rw                 = 1'b1;
        flags_d[FLG_ZERO]      = alu_zero;
        flags_d[FLG_CARRY]     = is_arith_op(s_q) ? alu_carry : 1'b0;
        flags_d[FLG_OVF]       = is_arith_op(s_q) ? alu_ovf   : 1'b0;
        flags_d[FLG_EQ]        = alu_eq;
        flags_d[FLG_GT]        = alu_gt;
        flags_d[FLG_LT]        = alu_lt;
        state_d                = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        f_d     = alu_f;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_rdy_sel) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, ALU operand and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      grant_q <= 1'b0;
      err_q   <= 1'b0;
      f_q     <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      f_q     <= f_d;
      flags_q <= flags_d;
    end
  end

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  assign rsp0_valid = (state_q == ST_RESP) && !grant_q;
  assign rsp1_valid = (state_q == ST_RESP) &&  grant_q;
  assign rsp0_f     = f_q;
  assign rsp1_f     = f_q;
  assign rsp0_flags = flags_q;
  assign rsp1_flags = flags_q;
  assign rsp0_err   = err_q && !grant_q;
  assign rsp1_err   = err_q &&  grant_q;

  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_s    = s_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

endmodule
